// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants and FSM state type.
package instr_fetch_unit_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J_TYPE = 6'h02;
    localparam logic [5:0] I_TYPE = 6'h04;

    typedef enum logic [1:0] {
        IFU_IDLE  = 2'd0,
        IFU_FETCH = 2'd1,
        IFU_ISSUE = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential pc+4.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr_word,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_offset;
    logic              unused_opcode;

    assign unused_opcode = ^instr_word[31:26];

    always_comb begin
        pc4           = pc + ADDR_W'(4);
        jump_target   = {pc4[ADDR_W-1:28], instr_word[25:0], 2'b00};
        branch_offset = {{(ADDR_W-18){instr_word[15]}}, instr_word[15:0], 2'b00};
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc4 + branch_offset;
        end else begin
            next_pc = pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: owns the PC, fetches over the imem req/ack bus and issues to the decoder.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    instr_fetch_unit_if.master imem,
    output logic               instr_valid,
    input  logic               dec_ready,
    output logic [5:0]         instruction,
    output logic [5:0]         func,
    output logic [31:0]        instr_word,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero,
    output logic [ADDR_W-1:0]  pc
);

    ifu_state_t        state;
    logic              req;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc         (pc),
        .instr_word (instr_word),
        .jump       (jump),
        .branch     (branch),
        .zero       (zero),
        .next_pc    (next_pc)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign instruction    = instr_word[31:26];
    assign func           = instr_word[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IFU_IDLE;
            pc          <= RESET_PC;
            req         <= 1'b0;
            instr_valid <= 1'b0;
            instr_word  <= '0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    if (enable) begin
                        state <= IFU_FETCH;
                        req   <= 1'b1;
                    end
                end
                IFU_FETCH: begin
                    // rdata is captured only here; acks seen in other states are dropped
                    if (imem.imem_ack) begin
                        instr_word  <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        req         <= 1'b0;
                        state       <= IFU_ISSUE;
                    end
                end
                IFU_ISSUE: begin
                    if (dec_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        if (enable) begin
                            state <= IFU_FETCH;
                            req   <= 1'b1;
                        end else begin
                            state <= IFU_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IFU_IDLE;
                    req         <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
